// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the PC redirect controller and its helpers.
package pc_redirect_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PEND  = 2'd1,
      FLUSH = 2'd2
   } redirect_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0000_0000;
   localparam int          PC_INC               = 4;
   localparam int          FLUSH_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/pc_redirect_ctrl_redirect_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module redirect_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !(&count_q)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Program counter owner: sequences EX-stage redirects, holds them across
// instruction-memory busy cycles and flushes the front end afterwards.
module pc_redirect_ctrl
   import pc_redirect_ctrl_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = XLEN'(RESET_PC_DEFAULT),
   parameter int              FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
   parameter int              CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_target,
   input  logic             imem_busy,
   input  logic             hazard_stall,
   output logic [XLEN-1:0]  pc_out,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_cnt
);

   redirect_state_e state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic [2:0]      fcnt_q, fcnt_d;
   logic            flush_q, flush_d;
   logic            mis_q, mis_d;
   logic            apply;
   logic [XLEN-1:0] apply_tgt;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      fcnt_d    = fcnt_q;
      flush_d   = flush_q;
      mis_d     = 1'b0;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      apply     = 1'b0;
      apply_tgt = tgt_q;

      unique case (state_q)
         RUN: begin
            if (redirect_valid) begin
               if (imem_busy) begin
                  stall_if = 1'b1;
                  tgt_d    = redirect_target;
                  state_d  = PEND;
               end else begin
                  apply     = 1'b1;
                  apply_tgt = redirect_target;
               end
            end else begin
               stall_if = imem_busy | hazard_stall;
               stall_id = hazard_stall;
               if (!(imem_busy | hazard_stall)) begin
                  pc_d = pc_q + XLEN'(PC_INC);
               end
            end
         end
         PEND: begin
            stall_if = 1'b1;
            if (!imem_busy) begin
               apply = 1'b1;
            end
         end
         FLUSH: begin
            // Wrong-path redirects and hazards are meaningless while squashing.
            stall_if = imem_busy;
            if (!imem_busy) begin
               pc_d = pc_q + XLEN'(PC_INC);
            end
            fcnt_d = fcnt_q - 3'd1;
            if (fcnt_q <= 3'd1) begin
               fcnt_d  = 3'd0;
               flush_d = 1'b0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (apply) begin
         pc_d    = {apply_tgt[XLEN-1:2], 2'b00};
         mis_d   = |apply_tgt[1:0];
         fcnt_d  = 3'(FLUSH_CYCLES);
         flush_d = 1'b1;
         state_d = FLUSH;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         fcnt_q  <= 3'd0;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         fcnt_q  <= fcnt_d;
         flush_q <= flush_d;
         mis_q   <= mis_d;
      end
   end

   redirect_counter #(
      .CNT_W (CNT_W)
   ) u_redirect_counter (
      .clk   (CLK),
      .rst_n (RESET_N),
      .inc   (apply),
      .count (redirect_cnt)
   );

   assign pc_out       = pc_q;
   assign flush_if_id  = flush_q;
   assign flush_id_ex  = flush_q;
   assign misalign_err = mis_q;

endmodule
